// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: req/gnt/rvalid data-memory handshake,
// lane steering, load extension, alignment and bus-timeout exceptions.
module mem_stage_lsu #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [3:0]          mem_op,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic                stall,
  output logic                out_valid,
  output logic [DATA_W-1:0]   rdata,
  output logic                exc,
  output logic [4:0]          exc_code,
  output logic [ADDR_W-1:0]   exc_badaddr,
  output logic                m_req,
  output logic                m_we,
  output logic [DATA_W/8-1:0] m_be,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic                m_gnt,
  input  logic                m_rvalid,
  input  logic [DATA_W-1:0]   m_rdata
);
  localparam int NB = DATA_W / 8;
  localparam int OW = $clog2(NB);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit W64 = (DATA_W == 64);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

  typedef struct packed {
    logic              ld;
    logic              sg;
    logic [1:0]        sz;
    logic [ADDR_W-1:0] addr;
    logic [NB-1:0]     be;
    logic [DATA_W-1:0] wd;
  } req_t;

  state_e            state_q, state_d;
  req_t              req_q, req_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ov_q, ov_d;
  logic              exc_q, exc_d;
  logic [4:0]        code_q, code_d;
  logic [ADDR_W-1:0] bad_q, bad_d;
  logic [DATA_W-1:0] rd_q, rd_d;

  logic              d_ld, d_st, d_sg, mis;
  logic [1:0]        d_sz;
  logic [OW-1:0]     off;
  logic [NB-1:0]     be;
  logic [DATA_W-1:0] lane, ext;
  logic              to_hit, fin, tmo;

  assign off = addr[OW-1:0];

  // 64-bit-only ops decode to none on a 32-bit bus
  always_comb begin
    d_ld = 1'b0;
    d_st = 1'b0;
    d_sg = 1'b0;
    d_sz = 2'd0;
    unique case (mem_op)
      4'b0001: d_st = 1'b1;
      4'b0010: begin d_st = 1'b1; d_sz = 2'd1; end
      4'b0011: begin d_st = 1'b1; d_sz = 2'd2; end
      4'b0100: begin d_st = W64;  d_sz = 2'd3; end
      4'b1000: begin d_ld = 1'b1; d_sg = 1'b1; end
      4'b1001: d_ld = 1'b1;
      4'b1010: begin d_ld = 1'b1; d_sg = 1'b1; d_sz = 2'd1; end
      4'b1011: begin d_ld = 1'b1; d_sz = 2'd1; end
      4'b1100: begin d_ld = 1'b1; d_sg = 1'b1; d_sz = 2'd2; end
      4'b1101: begin d_ld = W64;  d_sz = 2'd2; end
      4'b1110: begin d_ld = W64;  d_sz = 2'd3; end
      default: ;
    endcase
  end

  always_comb begin
    unique case (d_sz)
      2'd1:    begin mis = addr[0];       be = NB'(3) << off;  end
      2'd2:    begin mis = |addr[1:0];    be = NB'(15) << off; end
      2'd3:    begin mis = |addr[2:0];    be = '1;             end
      default: begin mis = 1'b0;          be = NB'(1) << off;  end
    endcase
  end

  always_comb begin
    lane = m_rdata >> {req_q.addr[OW-1:0], 3'b000};
    ext  = lane;
    for (int i = 8; i < DATA_W; i++)
      if (i >= (8 << req_q.sz))
        ext[i] = req_q.sg & lane[(8 << req_q.sz) - 1];
  end

  assign to_hit = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    ov_d    = 1'b0;
    exc_d   = 1'b0;
    rd_d    = '0;
    code_d  = code_q;
    bad_d   = bad_q;
    stall   = 1'b0;
    fin     = 1'b0;
    tmo     = 1'b0;
    unique case (state_q)
      IDLE: if (in_valid) begin
        if (!(d_ld || d_st)) begin
          ov_d = 1'b1;
        end else if (mis) begin
          ov_d   = 1'b1;
          exc_d  = 1'b1;
          code_d = d_ld ? 5'd4 : 5'd5;
          bad_d  = addr;
        end else begin
          stall      = 1'b1;
          state_d    = REQ;
          cnt_d      = '0;
          req_d.ld   = d_ld;
          req_d.sg   = d_sg;
          req_d.sz   = d_sz;
          req_d.addr = addr;
          req_d.be   = be;
          req_d.wd   = wdata << {off, 3'b000};
        end
      end
      REQ: begin
        cnt_d = cnt_q + CW'(1);
        if (m_gnt) begin
          if (!req_q.ld || m_rvalid) fin = 1'b1;
          else state_d = WAIT;
        end else if (to_hit) begin
          tmo = 1'b1;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (m_rvalid) fin = 1'b1;
        else if (to_hit) tmo = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (fin) begin
      ov_d    = 1'b1;
      rd_d    = req_q.ld ? ext : '0;
      state_d = IDLE;
    end
    if (tmo) begin
      ov_d    = 1'b1;
      exc_d   = 1'b1;
      code_d  = 5'd7;
      bad_d   = req_q.addr;
      state_d = IDLE;
    end
    if (state_q != IDLE) stall = !(fin || tmo);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= '0;
      cnt_q   <= '0;
      ov_q    <= 1'b0;
      exc_q   <= 1'b0;
      code_q  <= '0;
      bad_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      ov_q    <= ov_d;
      exc_q   <= exc_d;
      code_q  <= code_d;
      bad_q   <= bad_d;
      rd_q    <= rd_d;
    end
  end

  assign out_valid   = ov_q;
  assign exc         = exc_q;
  assign exc_code    = code_q;
  assign exc_badaddr = bad_q;
  assign rdata       = rd_q;
  assign m_req       = (state_q == REQ);
  assign m_we        = m_req & ~req_q.ld;
  assign m_be        = m_req ? req_q.be : '0;
  assign m_addr      = {req_q.addr[ADDR_W-1:OW], {OW{1'b0}}};
  assign m_wdata     = req_q.wd;

endmodule
